// File: rtl/gpi_pkg.sv
// Shared definitions for the general-purpose input block: register offsets
// and the byte-enable expansion used by all register writes.
package gpi_pkg;

    localparam logic [9:0] GPI_DATA_OFFSET       = 10'h000;
    localparam logic [9:0] GPI_RISE_EN_OFFSET    = 10'h004;
    localparam logic [9:0] GPI_FALL_EN_OFFSET    = 10'h008;
    localparam logic [9:0] GPI_INTR_STATE_OFFSET = 10'h00C;
    localparam logic [9:0] GPI_RAW_OFFSET        = 10'h010;

    localparam int unsigned GPI_BUS_WIDTH = 32;

    // Expand the four byte enables into a per-bit write mask.
    function automatic logic [GPI_BUS_WIDTH-1:0] gpi_be_to_mask(input logic [3:0] be);
        logic [GPI_BUS_WIDTH-1:0] mask;
        mask = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpi_debounce.sv
// Single-bit debounce filter: the output follows the input only after the
// input has differed from it for DebounceCycles consecutive cycles.
module gpi_debounce
    import gpi_pkg::*;
#(
    parameter int unsigned DebounceCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic deb_o
);

    if (DebounceCycles == 0) begin : g_bypass
        logic deb_q;

        // Filter disabled: register the input directly.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                deb_q <= 1'b0;
            end else begin
                deb_q <= raw_i;
            end
        end

        assign deb_o = deb_q;
    end else begin : g_filter
        localparam int unsigned CntW = $clog2(DebounceCycles + 1);
        localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

        logic [CntW-1:0] cnt_q, cnt_d;
        logic            deb_q, deb_d;

        // Count disagreeing cycles; commit the new level on the last one.
        always_comb begin
            cnt_d = cnt_q;
            deb_d = deb_q;
            if (raw_i == deb_q) begin
                cnt_d = {CntW{1'b0}};
            end else if (cnt_q == CntLast) begin
                deb_d = raw_i;
                cnt_d = {CntW{1'b0}};
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        // Filter state flops.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= {CntW{1'b0}};
                deb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_o = deb_q;
    end

endmodule

// File: rtl/gpi_intr.sv
// General-purpose input block: synchronized, debounced inputs with per-bit
// rise/fall interrupt enables, sticky W1C status and one level interrupt.
module gpi_intr
    import gpi_pkg::*;
#(
    parameter int unsigned GpiWidth       = 16,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic [GpiWidth-1:0] gp_i,
    output logic                gp_intr_o
);

    logic [GpiWidth-1:0] sync_q [SyncStages];
    logic [GpiWidth-1:0] raw_s;
    logic [GpiWidth-1:0] deb_s;
    logic [GpiWidth-1:0] deb_q;
    logic [GpiWidth-1:0] rise_s, fall_s, set_s, clr_s;

    logic [GpiWidth-1:0] rise_en_q, rise_en_d;
    logic [GpiWidth-1:0] fall_en_q, fall_en_d;
    logic [GpiWidth-1:0] intr_state_q, intr_state_d;

    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         rd_val_s;
    logic                gp_intr_q;

    logic [31:0]         wmask_s;
    logic [GpiWidth-1:0] wmask_g_s;
    logic [GpiWidth-1:0] wdata_g_s;
    logic [9:0]          offset_s;
    logic                wr_s;
    logic                unused_s;

    // Input synchronizer chain; the last stage is the raw sampled value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_q[s] <= {GpiWidth{1'b0}};
            end
        end else begin
            sync_q[0] <= gp_i;
            for (int s = 1; s < SyncStages; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign raw_s = sync_q[SyncStages-1];

    for (genvar g = 0; g < GpiWidth; g++) begin : g_deb
        gpi_debounce #(
            .DebounceCycles(DebounceCycles)
        ) u_deb (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .raw_i (raw_s[g]),
            .deb_o (deb_s[g])
        );
    end

    assign rise_s = deb_s & ~deb_q;
    assign fall_s = ~deb_s & deb_q;
    assign set_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);

    assign offset_s  = device_addr_i[9:0];
    assign wr_s      = device_req_i & device_we_i;
    assign wmask_s   = gpi_be_to_mask(device_be_i);
    assign wmask_g_s = wmask_s[GpiWidth-1:0];
    assign wdata_g_s = device_wdata_i[GpiWidth-1:0];
    assign unused_s  = ^{device_addr_i[31:10], device_wdata_i, wmask_s};

    // Read mux over the pre-write register state.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (offset_s)
            GPI_DATA_OFFSET:       rd_val_s = 32'(deb_s);
            GPI_RISE_EN_OFFSET:    rd_val_s = 32'(rise_en_q);
            GPI_FALL_EN_OFFSET:    rd_val_s = 32'(fall_en_q);
            GPI_INTR_STATE_OFFSET: rd_val_s = 32'(intr_state_q);
            GPI_RAW_OFFSET:        rd_val_s = 32'(raw_s);
            default:               rd_val_s = 32'h0000_0000;
        endcase
    end

    // Register writes; a hardware set beats a same-cycle W1C clear.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_s     = {GpiWidth{1'b0}};
        if (wr_s && (offset_s == GPI_RISE_EN_OFFSET)) begin
            rise_en_d = (rise_en_q & ~wmask_g_s) | (wdata_g_s & wmask_g_s);
        end else begin
            rise_en_d = rise_en_q;
        end
        if (wr_s && (offset_s == GPI_FALL_EN_OFFSET)) begin
            fall_en_d = (fall_en_q & ~wmask_g_s) | (wdata_g_s & wmask_g_s);
        end else begin
            fall_en_d = fall_en_q;
        end
        if (wr_s && (offset_s == GPI_INTR_STATE_OFFSET)) begin
            clr_s = wdata_g_s & wmask_g_s;
        end else begin
            clr_s = {GpiWidth{1'b0}};
        end
        intr_state_d = (intr_state_q & ~clr_s) | set_s;
    end

    // Read data is returned only for read requests.
    always_comb begin
        if (device_req_i && !device_we_i) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Register file, edge-detect history, bus response and interrupt flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_q        <= {GpiWidth{1'b0}};
            rise_en_q    <= {GpiWidth{1'b0}};
            fall_en_q    <= {GpiWidth{1'b0}};
            intr_state_q <= {GpiWidth{1'b0}};
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            gp_intr_q    <= 1'b0;
        end else begin
            deb_q        <= deb_s;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            intr_state_q <= intr_state_d;
            rvalid_q     <= device_req_i;
            rdata_q      <= rdata_d;
            gp_intr_q    <= |intr_state_q;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign gp_intr_o       = gp_intr_q;

endmodule

// File: doc/gpi_intr.md
Name: gpi_intr

Overview:
- General-purpose input block. It is the input-direction companion to the GPO device on the same device bus.
- Each input bit passes through a synchronizer, then a per-bit debounce filter.
- The block detects rising and falling edges on the debounced value and records enabled edges in a sticky interrupt status register.
- It drives one level interrupt into the core's fast-interrupt input. It is a bus responder using the same req/addr/we/be/wdata -> rvalid/rdata protocol as the other system devices.

Parameters:
- GpiWidth, 16, number of input bits (1..32).
- SyncStages, 2, synchronizer flop depth (>=2).
- DebounceCycles, 16, consecutive stable cycles required before the debounced bit changes. 0 = bypass.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- device_req_i  input  1  bus request
- device_addr_i  input  32  byte address; only [9:0] decoded
- device_we_i  input  1  write enable
- device_be_i  input  4  byte enables
- device_wdata_i  input  32  write data
- device_rvalid_o  output  1  response valid, one cycle after req
- device_rdata_o  output  32  read data, valid with rvalid
- gp_i  input  GpiWidth  asynchronous external inputs
- gp_intr_o  output  1  level interrupt = OR of INTR_STATE

Behaviour:
- Reset: all flops 0. device_rvalid_o=0, device_rdata_o=0, gp_intr_o=0. Sync chain, debounced value, counters, RISE_EN, FALL_EN and INTR_STATE are all 0.
- Sync: gp_i passes through SyncStages flops to give raw.
- Debounce, per bit, with a counter of width $clog2(DebounceCycles+1):
  - If raw==deb, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DebounceCycles-1 while raw!=deb, deb<=raw and the counter clears on the same cycle.
  - A glitch shorter than DebounceCycles cycles never reaches deb.
  - DebounceCycles=0: deb<=raw every cycle.
- Edge detect: rise=deb&~deb_q, fall=~deb&deb_q, where deb_q is deb delayed one cycle.
- Status set: INTR_STATE[i] is set the cycle after a rise with RISE_EN[i]=1, or a fall with FALL_EN[i]=1.
- Latency: pin change to gp_intr_o high = SyncStages+DebounceCycles+2 cycles.
- Register map, addr[9:0]:
  - 0x000 DATA (RO): deb.
  - 0x004 RISE_EN (RW).
  - 0x008 FALL_EN (RW).
  - 0x00C INTR_STATE (RW1C).
  - 0x010 RAW (RO): synchronized, undebounced.
  - Other offsets read 0; writes to them are ignored.
  - Bits >= GpiWidth read 0.
- Writes: take effect when req&we. Per-byte: byte k is affected only if be[k]=1. RW1C clears bits where wdata=1 and be covers that bit.
- Simultaneous hardware set and software clear on the same bit in the same cycle: set wins, bit stays 1.
- Enable change: clearing RISE_EN/FALL_EN does not clear pending INTR_STATE bits.
- Bus response:
  - device_rvalid_o <= device_req_i every cycle; no back-pressure; one request per cycle accepted.
  - device_rdata_o <= read value of addressed register in the request cycle; 0 for writes.
  - Read data reflects register state before any same-cycle write.
- gp_intr_o = |INTR_STATE, driven from flops with no combinational input path.
- Reset asserted mid-debounce or with pending interrupts: everything returns to reset values. An input held high through reset yields a rise event DebounceCycles+SyncStages+1 cycles after release; it is masked because RISE_EN=0.

Decomposition:
- Package gpi_pkg: register offset localparams (GPI_DATA_OFFSET=10'h000, GPI_RISE_EN_OFFSET=10'h004, GPI_FALL_EN_OFFSET=10'h008, GPI_INTR_STATE_OFFSET=10'h00C, GPI_RAW_OFFSET=10'h010).
- Sub-module gpi_debounce: one bit, parameter DebounceCycles, ports clk_i/rst_ni/raw_i/deb_o. Instantiated GpiWidth times in a generate loop.
- Synchronizer and register file stay in gpi_intr.

Test Plan (GpiWidth=16, SyncStages=2, DebounceCycles=4):
- Reset, then read 0x000/0x004/0x008/0x00C/0x010 -> each rvalid exactly one cycle after req, rdata=0, gp_intr_o=0.
- Glitch: gp_i[3]=1 for 3 cycles, then 0 -> RAW[3] pulses, DATA stays 0x0000, INTR_STATE stays 0.
- Rise: write RISE_EN=0x0008, then hold gp_i[3]=1 -> DATA=0x0008; gp_intr_o rises exactly 8 cycles after the pin edge; INTR_STATE=0x0008.
- W1C with byte enable: INTR_STATE=0x0108. Write 0x0108 with be=4'b0001 -> INTR_STATE=0x0100, gp_intr_o stays 1. Write 0x0100 with be=4'b0010 -> INTR_STATE=0, gp_intr_o=0.
- Set/clear collision: FALL_EN[5]=1. Schedule the debounced fall of bit 5 in the same cycle as a W1C write of 0x0020 -> INTR_STATE[5]=1 afterwards.
- Unmapped access: write 0xFFFF to 0x014, read 0x014 -> rdata=0, all other registers unchanged. Assert reset mid-debounce -> counters clear, DATA=0.
